// File: rtl/top.sv
// Fault-tolerant up-counter: each data nibble of the state register carries a
// Hamming(7,4) code and is corrected and scrubbed every cycle.
module top #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] counter
);

    localparam int unsigned NIB = WIDTH / 4;

    logic [WIDTH-1:0] count_reg;
    logic [3*NIB-1:0] parity_stored;

    logic [WIDTH-1:0] corrected;
    logic [WIDTH-1:0] next_count;
    logic [3*NIB-1:0] next_parity;

    function automatic logic [2:0] encode(input logic [3:0] d);
        encode[0] = d[0] ^ d[1] ^ d[3];
        encode[1] = d[0] ^ d[2] ^ d[3];
        encode[2] = d[1] ^ d[2] ^ d[3];
    endfunction

    function automatic logic [3:0] decode(input logic [3:0] d, input logic [2:0] p);
        logic [2:0] s;
        s = p ^ encode(d);
        decode = d;
        // Syndromes 1, 2 and 4 point at a parity bit, so the data is left alone.
        case (s)
            3'd3:    decode[0] = ~d[0];
            3'd5:    decode[1] = ~d[1];
            3'd6:    decode[2] = ~d[2];
            3'd7:    decode[3] = ~d[3];
            default: decode = d;
        endcase
    endfunction

    always_comb begin
        corrected   = '0;
        next_parity = '0;
        for (int i = 0; i < NIB; i++) begin
            corrected[4*i +: 4] = decode(count_reg[4*i +: 4], parity_stored[3*i +: 3]);
        end
        next_count = enable ? corrected + 1'b1 : corrected;
        for (int i = 0; i < NIB; i++) begin
            next_parity[3*i +: 3] = encode(next_count[4*i +: 4]);
        end
    end

    assign counter = corrected;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg     <= '0;
            parity_stored <= '0;
        end else begin
            count_reg     <= next_count;
            parity_stored <= next_parity;
        end
    end

endmodule

// File: tb/tb_top.sv
// Directed bench for the Hamming-protected counter: a scoreboard queue holds
// expected counts, and faults are injected into the state registers by force.
module tb_top;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] counter;

    int passed = 0;
    int total  = 0;

    logic [15:0] exp_cnt;
    logic [15:0] sb[$];

    top #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .counter (counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] enc(input logic [3:0] d);
        enc = {d[1] ^ d[2] ^ d[3], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    endfunction

    function automatic logic [11:0] enc_all(input logic [15:0] v);
        enc_all = {enc(v[15:12]), enc(v[11:8]), enc(v[7:4]), enc(v[3:0])};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, expv);
    endtask

    // Drives one cycle, queues the predicted count and compares it after the edge.
    task automatic cycle(input logic en);
        enable = en;
        if (en) exp_cnt = exp_cnt + 16'd1;
        sb.push_back(exp_cnt);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            $error("FAIL scoreboard: queue empty");
        end else begin
            check("counter", counter, sb.pop_front());
        end
    endtask

    task automatic inject(input logic [15:0] cnt, input logic [11:0] par);
        @(negedge clk);
        force dut.count_reg     = cnt;
        force dut.parity_stored = par;
        #1;
        release dut.count_reg;
        release dut.parity_stored;
        #1;
    endtask

    initial begin
        reset   = 1'b0;
        enable  = 1'b0;
        exp_cnt = 16'h0000;

        // Reset
        @(posedge clk);
        #1;
        check("reset_counter", counter, 16'h0000);
        check("reset_parity", {4'h0, dut.parity_stored}, 16'h0000);
        reset = 1'b1;

        // Count 30, then hold 3
        for (int i = 0; i < 30; i++) cycle(1'b1);
        check("count_30", counter, 16'h001E);
        for (int i = 0; i < 3; i++) cycle(1'b0);
        check("hold_30", counter, 16'h001E);
        check("hold_parity", {4'h0, dut.parity_stored}, {4'h0, enc_all(16'h001E)});

        // Single data-bit error in nibble 0
        enable = 1'b0;
        inject(16'h0016, enc_all(16'h001E));
        check("inject_raw", dut.count_reg, 16'h0016);
        check("mask_bit3", counter, 16'h001E);
        cycle(1'b0);
        check("scrub_bit3", dut.count_reg, 16'h001E);
        cycle(1'b1);
        cycle(1'b1);
        check("after_reenable", counter, 16'h0020);

        // Errors in nibbles 0 and 3 at once
        inject(exp_cnt ^ 16'h8001, enc_all(exp_cnt));
        check("mask_two_nibbles", counter, exp_cnt);
        cycle(1'b0);
        check("scrub_two_nibbles", dut.count_reg, exp_cnt);

        // Parity-only error in nibble 1
        inject(exp_cnt, enc_all(exp_cnt) ^ 12'h010);
        check("parity_err_counter", counter, exp_cnt);
        cycle(1'b0);
        check("parity_scrubbed", {4'h0, dut.parity_stored}, {4'h0, enc_all(exp_cnt)});

        // Wrap from 0xFFFF
        exp_cnt = 16'hFFFF;
        inject(16'hFFFF, enc_all(16'hFFFF));
        check("preload", counter, 16'hFFFF);
        cycle(1'b1);
        check("wrap", counter, 16'h0000);
        check("wrap_parity", {4'h0, dut.parity_stored}, 16'h0000);
        for (int i = 0; i < 5; i++) cycle(1'b1);

        // Error combined with enable: increment must use the corrected value
        inject(exp_cnt ^ 16'h0040, enc_all(exp_cnt));
        cycle(1'b1);

        // Reset mid-count with enable held and an error pending
        inject(exp_cnt ^ 16'h0100, enc_all(exp_cnt));
        reset  = 1'b0;
        enable = 1'b1;
        exp_cnt = 16'h0000;
        sb.push_back(exp_cnt);
        @(posedge clk);
        #1;
        check("mid_reset", counter, sb.pop_front());
        reset = 1'b1;
        cycle(1'b1);
        check("post_reset_count", counter, 16'h0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
